// File: rtl/xform_fifo.sv
// Transforming FIFO: each accepted word is passed, inverted, XOR-masked or
// incremented at push time, buffered, and presented on a valid/ready output.
module xform_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] mask,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic [WIDTH-1:0] xform_data;
  logic             push;
  logic             pop;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    xform_data = in_data;
    case (mode)
      2'b00: xform_data = in_data;
      2'b01: xform_data = ~in_data;
      2'b10: xform_data = in_data ^ mask;
      2'b11: xform_data = in_data + WIDTH'(1);
      default: xform_data = in_data;
    endcase
  end

  always_comb begin
    count_nxt = count;
    if (flush) begin
      count_nxt = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_nxt = count + 1'b1;
        2'b01:   count_nxt = count - 1'b1;
        default: count_nxt = count;
      endcase
    end
  end

  // in_ready and out_valid are registered from the next occupancy so that
  // neither handshake has a combinational path through the other side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      count     <= count_nxt;
      in_ready  <= (count_nxt != FULL);
      out_valid <= (count_nxt != '0);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem[wr_ptr] <= xform_data;
  end

  assign out_data = out_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_xform_fifo.sv
// Directed self-checking bench for xform_fifo (WIDTH=8, DEPTH=4).
module tb_xform_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [1:0] mode;
  logic [7:0] mask;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] count;

  int checks = 0;
  int errors = 0;

  xform_fifo #(.WIDTH(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .mask(mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] sweep_exp [4];

  initial begin
    sweep_exp[0] = 8'h3C; sweep_exp[1] = 8'hC3; sweep_exp[2] = 8'hC3; sweep_exp[3] = 8'h3D;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; mode = '0; mask = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    step();
    rst = 1'b0;
    step();

    // mode sweep, back-to-back with out_ready=1
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h3C; mask = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      mode = 2'(i);
      step();
      chk($sformatf("sweep_data%0d", i), 32'(out_data), 32'(sweep_exp[i]));
      chk($sformatf("sweep_cnt%0d", i), 32'(count), 1);
    end
    in_valid = 1'b0;
    step();
    chk("sweep_empty", 32'(out_valid), 0);

    // wrap and full
    out_ready = 1'b0; mode = 2'b00; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_data = 8'(i);
      step();
    end
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    chk("full_head", 32'(out_data), 1);
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(out_data), 32'(i));
      step();
    end
    chk("drain_count", 32'(count), 0);
    chk("drain_valid", 32'(out_valid), 0);

    // simultaneous push/pop at count=2
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'hA0; step();
    in_data = 8'hA1; step();
    chk("pp_prefill", 32'(count), 2);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'hA2 + 8'(i);
      chk($sformatf("pp_data%0d", i), 32'(out_data), 32'(8'hA0 + 8'(i)));
      step();
      chk($sformatf("pp_cnt%0d", i), 32'(count), 2);
    end
    in_valid = 1'b0;
    chk("pp_tail0", 32'(out_data), 32'h A8);
    step();
    chk("pp_tail1", 32'(out_data), 32'h A9);
    step();
    chk("pp_empty", 32'(count), 0);

    // increment overflow, stored word immune to later mode change
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'hFF; mode = 2'b11;
    step();
    in_valid = 1'b0; mode = 2'b00;
    step();
    chk("inc_valid", 32'(out_valid), 1);
    chk("inc_wrap", 32'(out_data), 0);
    out_ready = 1'b1;
    step();
    chk("inc_popped", 32'(count), 0);

    // flush beats a concurrent push
    out_ready = 1'b0; in_valid = 1'b1; mode = 2'b00;
    in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_data = 8'h33; step();
    chk("fl_pre", 32'(count), 3);
    in_data = 8'hAA; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_count", 32'(count), 0);
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    step();
    chk("fl_noaa", 32'(out_valid), 0);
    in_valid = 1'b1; in_data = 8'h44;
    step();
    in_valid = 1'b0;
    chk("fl_new", 32'(out_data), 32'h44);
    step();

    // async reset mid-cycle
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = 8'h01; step();
    in_data = 8'h02; step();
    in_valid = 1'b0;
    chk("ar_pre", 32'(count), 2);
    #2 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_count", 32'(count), 0);
    chk("ar_data", 32'(out_data), 0);
    chk("ar_ready", 32'(in_ready), 1);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; mode = 2'b01;
    step();
    in_valid = 1'b0;
    chk("ar_first", 32'(out_data), 32'hA5);
    chk("ar_cnt1", 32'(count), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
